// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//   Multiply: one shift-add step per cycle on operand magnitudes.
//   Divide:   one restoring step per cycle on operand magnitudes.
//   Divide-by-zero, signed overflow and illegal W encodings complete in one cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              abandon any in-flight op (returns to IDLE)
//   start_valid/ready  op request handshake (ready only in IDLE)
//   funct3, is_word    op select, RV64 W-variant (ignored when XLEN=32)
//   op_a, op_b         rs1, rs2
//   result, illegal    response payload, qualified by result_valid
//   result_valid/ready response handshake
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            illegal
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier, quo, dvsr;
  logic [XLEN:0]     rmd;
  logic [2:0]        op_q;
  logic              word_q, neg_q, neg_r;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- request decode ----------------
  logic            wd, sa_use, sb_use, sa, sb;
  logic            div_zero, div_ovf, w_ill, fast;
  logic [XLEN-1:0] a_v, b_v, mag_a, mag_b, min_v, fast_res;

  assign wd     = (XLEN == 64) ? is_word : 1'b0;
  assign sa_use = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign sb_use = funct3 inside {3'b001, 3'b100, 3'b110};

  // W-variants see only the low word: sign- or zero-extend it per operand signedness
  assign a_v = wd ? (sa_use ? sext32(op_a[31:0]) : XLEN'(op_a[31:0])) : op_a;
  assign b_v = wd ? (sb_use ? sext32(op_b[31:0]) : XLEN'(op_b[31:0])) : op_b;
  assign sa    = sa_use & a_v[XLEN-1];
  assign sb    = sb_use & b_v[XLEN-1];
  assign mag_a = sa ? -a_v : a_v;
  assign mag_b = sb ? -b_v : b_v;

  assign min_v    = wd ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = funct3[2] && (b_v == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (a_v == min_v) && (b_v == '1);
  assign w_ill    = wd && (funct3 inside {3'b001, 3'b010, 3'b011});
  assign fast     = w_ill | div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = funct3[1] ? (wd ? sext32(op_a[31:0]) : op_a) : '1;
    else if (div_ovf)
      fast_res = funct3[1] ? '0 : a_v;
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0] rshift, rdiff;
  logic          ge;

  assign rshift = {rmd[XLEN-1:0], quo[XLEN-1]};
  assign rdiff  = rshift - {1'b0, dvsr};
  assign ge     = ~rdiff[XLEN];  // no borrow: partial remainder >= divisor

  // ---------------- sign fixup ----------------
  logic [2*XLEN-1:0] p_fix;
  logic [XLEN-1:0]   q_fix, r_fix, raw, fix_res;
  logic [CW-1:0]     n_iter;

  assign p_fix  = neg_q ? -acc : acc;
  assign q_fix  = neg_q ? -quo : quo;
  assign r_fix  = neg_r ? -rmd[XLEN-1:0] : rmd[XLEN-1:0];
  assign n_iter = word_q ? CW'(32) : CW'(XLEN);

  always_comb begin
    if (!op_q[2]) raw = (op_q == 3'b000) ? acc[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
    else          raw = op_q[1] ? r_fix : q_fix;
    fix_res = word_q ? sext32(raw[31:0]) : raw;
  end

  assign start_ready = (state == IDLE);

  // ---------------- control + state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          op_q   <= funct3;
          word_q <= wd;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {{XLEN{1'b0}}, mag_a};
          mplier <= mag_b;
          dvsr   <= mag_b;
          // W divide: park the 32-bit dividend at the top so its MSB shifts out first
          quo    <= wd ? (mag_a << (XLEN - 32)) : mag_a;
          rmd    <= '0;
          if (fast) begin
            state        <= DONE;
            result       <= fast_res;
            illegal      <= w_ill;
            result_valid <= 1'b1;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: if (cnt == n_iter) begin
          // all steps done; this edge applies the sign fixup
          state        <= DONE;
          cnt          <= '0;
          result       <= fix_res;
          illegal      <= 1'b0;
          result_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
          if (op_q[2]) begin
            rmd <= ge ? rdiff : rshift;
            quo <= {quo[XLEN-2:0], ge};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        DONE: if (result_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          illegal      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=64).
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, flush, start_valid, start_ready, is_word;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b, result;
  logic        result_valid, result_ready, illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b, res;
    logic        ill;
    int          lat;
  } vec_t;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .funct3(funct3), .is_word(is_word), .op_a(op_a), .op_b(op_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Drive one request, scramble inputs after the accept edge, and measure
  // edges from accept to first result_valid (-1 on timeout).
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, b,
                       output int lat);
    funct3 = f; is_word = w; op_a = a; op_b = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; op_a = ~a; op_b = ~b; funct3 = ~f; is_word = ~w;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = k; break; end
    end
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    vec_t v[7];
    int   lat;
    v[0] = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 65};
    v[1] = '{3'b000, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 1'b0, 65};
    v[2] = '{3'b000, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33};
    v[3] = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
    v[4] = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65};
    v[5] = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65};
    v[6] = '{3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1'b0, 65};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].f, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL mul_res[%0d]: got %h want %h", i, result, v[i].res); end
      n_cmp++; if (illegal !== v[i].ill) begin n_err++; $display("FAIL mul_ill[%0d]: got %b want %b", i, illegal, v[i].ill); end
      consume();
      n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL mul_consume[%0d]: got %b want 0", i, result_valid); end
    end
  endtask

  task automatic test_div();
    vec_t v[12];
    int   lat;
    v[0]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65};
    v[1]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65};
    v[2]  = '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 65};
    v[3]  = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 65};
    v[4]  = '{3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65};
    v[5]  = '{3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 65};
    v[6]  = '{3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
    v[7]  = '{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33};
    v[8]  = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33};
    v[9]  = '{3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 64'd5, 1'b0, 33};
    // signed overflow: fast path
    v[10] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1};
    v[11] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1};
    for (int i = 0; i < 12; i++) begin
      issue(v[i].f, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL div_res[%0d]: got %h want %h", i, result, v[i].res); end
      n_cmp++; if (illegal !== v[i].ill) begin n_err++; $display("FAIL div_ill[%0d]: got %b want %b", i, illegal, v[i].ill); end
      consume();
    end
    issue(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL div_ovf64_lat: got %0d want 1", lat); end
    n_cmp++; if (result !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL div_ovf64_res: got %h want 8000000000000000", result); end
    consume();
  endtask

  task automatic test_div_zero();
    vec_t v[4];
    int   lat;
    v[0] = '{3'b101, 1'b0, 64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
    v[1] = '{3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b0, 1};
    v[2] = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
    // W: divisor low word is zero even though the upper half is not
    v[3] = '{3'b110, 1'b1, 64'h1234_5678_8000_0001, 64'h9_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b0, 1};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].f, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL dz_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL dz_res[%0d]: got %h want %h", i, result, v[i].res); end
      n_cmp++; if (illegal !== v[i].ill) begin n_err++; $display("FAIL dz_ill[%0d]: got %b want %b", i, illegal, v[i].ill); end
      consume();
    end
  endtask

  task automatic test_illegal();
    logic [2:0] fs [3];
    int lat;
    fs[0] = 3'b001; fs[1] = 3'b010; fs[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      issue(fs[i], 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h3, lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL ill_lat[%0d]: got %0d want 1", i, lat); end
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag[%0d]: got %b want 1", i, illegal); end
      n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL ill_res[%0d]: got %h want 0", i, result); end
      consume();
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear[%0d]: got %b want 0", i, illegal); end
    end
  endtask

  task automatic test_flush_reset();
    int seen;
    // flush mid-BUSY
    funct3 = 3'b000; is_word = 1'b0; op_a = 64'd5; op_b = 64'd9; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_cmp++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", start_ready); end
    repeat (10) @(posedge clk);
    #1; flush = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start_valid = 1'b0;
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got %b want 1", start_ready); end
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (result_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    // flush together with a start in IDLE: not accepted
    flush = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start_valid = 1'b0;
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL flush_start_rejected: got %b want 1", start_ready); end
    // reset mid-BUSY, also asserting flush and start
    funct3 = 3'b101; op_a = 64'd1000; op_b = 64'd3; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst = 1'b1; flush = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start_valid = 1'b0;
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", start_ready); end
    n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (result_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat);
    n_cmp++; if (lat != 65) begin n_err++; $display("FAIL hold_lat: got %0d want 65", lat); end
    // queue the next op while the result is held
    funct3 = 3'b101; is_word = 1'b0; op_a = 64'd100; op_b = 64'd7; start_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFEB || start_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL b2b_consumed: got %b want 0", result_valid); end
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL b2b_not_accepted: got %b want 1", start_ready); end
    @(posedge clk); #1;
    start_valid = 1'b0; op_a = 64'd0; op_b = 64'd0;
    n_cmp++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accepted: got %b want 0", start_ready); end
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = k; break; end
    end
    n_cmp++; if (lat != 65) begin n_err++; $display("FAIL b2b_lat: got %0d want 65", lat); end
    n_cmp++; if (result !== 64'd14) begin n_err++; $display("FAIL b2b_res: got %h want e", result); end
    consume();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    funct3 = 3'b000; is_word = 1'b0; op_a = '0; op_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_illegal();
    test_flush_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  abandon any in-flight operation.
REQ-005 Port: start_valid  input  1  operation request.
REQ-006 Port: start_ready  output  1  high only in IDLE; an op is accepted on an edge with start_valid && start_ready.
REQ-007 Port: funct3  input  3  M-extension op select.
REQ-008 Port: is_word  input  1  RV64 W-variant; ignored (treated 0) when XLEN=32.
REQ-009 Port: op_a, op_b  input  XLEN  operands (rs1, rs2).
REQ-010 Port: result  output  XLEN  operation result, valid while result_valid.
REQ-011 Port: result_valid  output  1  result available.
REQ-012 Port: result_ready  input  1  consumer accepts result.
REQ-013 Port: illegal  output  1  qualified by result_valid; request was an undefined encoding.

Function
REQ-014 Decode: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 W-variant: legal for 000, 100, 101, 110 and 111; operates on the low 32 bits of the operands; result = 32-bit result sign-extended from bit 31 to XLEN.
REQ-016 W-variant with funct3 001, 010 or 011: illegal=1, result=0, fast path.
REQ-017 Operands are latched on the accepting edge; later changes to the inputs have no effect.
REQ-018 State machine: IDLE, BUSY, DONE.
  - IDLE -> BUSY on accept.
  - IDLE -> DONE on accept for fast-path cases.
  - BUSY -> DONE after N iterations.
  - DONE -> IDLE on an edge with result_ready=1.
REQ-019 Iterations: N = 32 if is_word, else XLEN.
  - Multiply: one shift-add step per edge.
  - Divide: one restoring step per edge, on operand magnitudes.
  - Sign fixup is applied on the edge that enters DONE.
REQ-020 Latency:
  - Iterative op accepted on edge E: result_valid first high after edge E+N+1.
  - Fast-path op accepted on edge E: result_valid first high after edge E+1.
REQ-021 MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits.
  - MULH: signed x signed.
  - MULHSU: signed op_a x unsigned op_b.
  - MULHU: unsigned x unsigned.
REQ-022 Division rounds toward zero. The remainder takes the sign of the dividend.
REQ-023 Divide by zero is fast path, with illegal=0:
  - Quotient = all ones.
  - Remainder = dividend.
REQ-024 Signed overflow (dividend = most-negative, divisor = -1; W: 32-bit width) is fast path:
  - Quotient = dividend.
  - Remainder = 0.
REQ-025 result, illegal and result_valid hold stable in DONE until result_ready=1.
REQ-026 A result is consumed on an edge with result_valid && result_ready. That edge returns the block to IDLE, and result_valid is low in the following cycle.
REQ-027 No new op is accepted in the same edge that consumes a result. Maximum throughput is one op per N+3 cycles (iterative).
REQ-028 Flush is sampled in every state and has priority over start and result_ready.
  - The next state is IDLE.
  - result_valid is 0 after the edge.
  - A start_valid in the same cycle is not accepted.
REQ-029 result, when result_valid=0, is don't-care. illegal is 0 whenever result_valid=0.

Reset
REQ-030 rst=1 at an edge forces, in any state including mid-iteration:
  - State IDLE, iteration counter 0.
  - result_valid=0, illegal=0, result=0.
  - start_ready=1 after the edge.
REQ-031 rst has priority over flush, start_valid and result_ready.

Verification
REQ-032 XLEN=64, MUL op_a=7, op_b=-3 -> result=0xFFFFFFFFFFFFFFEB; result_valid high after edge E+65.
REQ-033 XLEN=64, MULHU op_a=op_b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE. MULH on the same operands -> result=0.
REQ-034 XLEN=64, DIV op_a=-7, op_b=2 -> result=-3. REM on the same operands -> result=-1. DIVW op_a=0x00000000_80000000, op_b=-1 -> result=0xFFFFFFFF80000000 after edge E+1.
REQ-035 DIVU op_b=0 -> result all ones. REMU op_a=0x1234, op_b=0 -> result=0x1234; both after edge E+1, illegal=0.
REQ-036 is_word=1 with funct3=001 -> result_valid after edge E+1, illegal=1, result=0.
REQ-037 Control sequence:
  - Flush, then rst, asserted mid-BUSY -> IDLE next edge, result_valid never asserted.
  - result_ready held low for 5 cycles in DONE -> result held stable.
  - start_valid held high during DONE -> not accepted until after consumption.
